// File: rtl/uart_stress_engine.sv
// UART traffic engine: echo FIFO loopback, LFSR pattern generate/check, and saturating error statistics.
// Latency: rx strobe to counter/sticky update 1 cycle; enqueue to tx_v_o 1 cycle.
// Backpressure: tx_v_o is held until tx_ready_and_i; echo bytes arriving with the FIFO full are dropped and counted.
//
// Ports: clk_i/reset_n_i (async active-low); mode_i selects echo/gen/check/gen+check; clear_i zeroes
// statistics; rx_* is the receiver strobe, byte and error qualifiers; tx_v_o/tx_o/tx_ready_and_i is the
// transmitter handshake; *_count_o are saturating counters; sticky_o = {mismatch, overflow, frame, parity};
// timeout_o flags a silent receiver in check modes.
// Optional macro UART_STRESS_TIMEOUT_EN adds the check-mode watchdog; otherwise timeout_o is tied to 0.
module uart_stress_engine #(
    parameter int unsigned data_bits_p      = 8,
    parameter int unsigned buffer_els_p     = 16,
    parameter int unsigned count_width_p    = 16,
    parameter logic [15:0] lfsr_seed_p      = 16'hACE1,
    parameter int unsigned timeout_cycles_p = 1000000
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [1:0]               mode_i,
    input  logic                     clear_i,
    input  logic                     rx_v_i,
    input  logic [data_bits_p-1:0]   rx_i,
    input  logic                     rx_parity_error_i,
    input  logic                     rx_frame_error_i,
    output logic                     tx_v_o,
    output logic [data_bits_p-1:0]   tx_o,
    input  logic                     tx_ready_and_i,
    output logic [count_width_p-1:0] rx_count_o,
    output logic [count_width_p-1:0] tx_count_o,
    output logic [count_width_p-1:0] parity_err_count_o,
    output logic [count_width_p-1:0] frame_err_count_o,
    output logic [count_width_p-1:0] overflow_count_o,
    output logic [count_width_p-1:0] mismatch_count_o,
    output logic [3:0]               sticky_o,
    output logic                     timeout_o
);
    localparam int unsigned ptr_w = $clog2(buffer_els_p);

    if (data_bits_p < 5 || data_bits_p > 9 || buffer_els_p < 2 ||
        (buffer_els_p & (buffer_els_p - 1)) != 0 || lfsr_seed_p == 16'h0 ||
        timeout_cycles_p == 0) begin : g_param_check
        $error("uart_stress_engine: illegal parameter combination");
    end

    typedef enum logic [2:0] {DRAIN, ECHO, GEN, CHECK, GENCHK} state_t;

    state_t                 state;
    logic [1:0]             mode_r;
    logic [15:0]            tx_lfsr;
    logic [15:0]            chk_lfsr;
    logic                   gen_pend;   // generator byte offered before a mode change, still owed a handshake
    logic [data_bits_p-1:0] mem [buffer_els_p];
    logic [ptr_w-1:0]       rd_ptr;
    logic [ptr_w-1:0]       wr_ptr;
    logic [ptr_w:0]         fill;

    logic fifo_empty, fifo_full, in_drain, gen_active, chk_active;
    logic good, tx_hs, deq, enq_try, enq, ovf, mismatch, parity_hit, frame_hit;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [count_width_p-1:0] bump(input logic [count_width_p-1:0] c,
                                                      input logic inc, input logic clr);
        if (clr)
            return '0;
        if (inc && c != '1)
            return c + 1'b1;
        return c;
    endfunction

    function automatic state_t mode_state(input logic [1:0] m);
        case (m)
            2'd0:    return ECHO;
            2'd1:    return GEN;
            2'd2:    return CHECK;
            default: return GENCHK;
        endcase
    endfunction

    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == (ptr_w + 1)'(buffer_els_p));
    assign in_drain   = (state == DRAIN);
    assign gen_active = (state == GEN) || (state == GENCHK);
    assign chk_active = (state == CHECK) || (state == GENCHK);

    always_comb begin
        tx_v_o = 1'b0;
        tx_o   = mem[rd_ptr];
        case (state)
            ECHO: tx_v_o = !fifo_empty;
            GEN, GENCHK: begin
                tx_v_o = 1'b1;
                tx_o   = tx_lfsr[data_bits_p-1:0];
            end
            DRAIN: begin
                if (gen_pend) begin
                    tx_v_o = 1'b1;
                    tx_o   = tx_lfsr[data_bits_p-1:0];
                end else begin
                    tx_v_o = !fifo_empty;
                end
            end
            default: tx_v_o = 1'b0;
        endcase
    end

    assign tx_hs      = tx_v_o && tx_ready_and_i;
    assign deq        = tx_hs && ((state == ECHO) || (in_drain && !gen_pend));
    assign good       = rx_v_i && !rx_parity_error_i && !rx_frame_error_i;
    assign enq_try    = good && (state == ECHO);
    // A same-cycle dequeue frees the slot, so a full FIFO still accepts the byte.
    assign enq        = enq_try && (!fifo_full || deq);
    assign ovf        = enq_try && fifo_full && !deq;
    assign mismatch   = good && chk_active && (rx_i != chk_lfsr[data_bits_p-1:0]);
    // Bytes arriving while draining only bump rx_count_o.
    assign parity_hit = rx_v_i && rx_parity_error_i && !in_drain;
    assign frame_hit  = rx_v_i && rx_frame_error_i && !in_drain;

    always_ff @(posedge clk_i) begin
        if (enq)
            mem[wr_ptr] <= rx_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state              <= DRAIN;
            mode_r             <= 2'd0;
            tx_lfsr            <= lfsr_seed_p;
            chk_lfsr           <= lfsr_seed_p;
            gen_pend           <= 1'b0;
            rd_ptr             <= '0;
            wr_ptr             <= '0;
            fill               <= '0;
            rx_count_o         <= '0;
            tx_count_o         <= '0;
            parity_err_count_o <= '0;
            frame_err_count_o  <= '0;
            overflow_count_o   <= '0;
            mismatch_count_o   <= '0;
            sticky_o           <= 4'b0000;
        end else begin
            rx_count_o         <= bump(rx_count_o, rx_v_i, clear_i);
            tx_count_o         <= bump(tx_count_o, tx_hs, clear_i);
            parity_err_count_o <= bump(parity_err_count_o, parity_hit, clear_i);
            frame_err_count_o  <= bump(frame_err_count_o, frame_hit, clear_i);
            overflow_count_o   <= bump(overflow_count_o, ovf, clear_i);
            mismatch_count_o   <= bump(mismatch_count_o, mismatch, clear_i);
            sticky_o           <= clear_i ? 4'b0000
                                          : (sticky_o | {mismatch, ovf, frame_hit, parity_hit});

            if (enq)
                wr_ptr <= wr_ptr + 1'b1;
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
            fill <= fill + (ptr_w + 1)'(enq) - (ptr_w + 1)'(deq);

            if (tx_hs && gen_active)
                tx_lfsr <= lfsr_step(tx_lfsr);
            // Errored bytes still advance the checker so the stream stays aligned.
            if (rx_v_i && chk_active)
                chk_lfsr <= lfsr_step(chk_lfsr);

            case (state)
                DRAIN: begin
                    if (fifo_empty && !gen_pend) begin
                        state    <= mode_state(mode_i);
                        mode_r   <= mode_i;
                        tx_lfsr  <= lfsr_seed_p;
                        chk_lfsr <= lfsr_seed_p;
                    end else if (gen_pend && tx_hs) begin
                        gen_pend <= 1'b0;
                    end
                end
                default: begin
                    if (mode_i != mode_r) begin
                        state    <= DRAIN;
                        gen_pend <= gen_active && !tx_ready_and_i;
                    end
                end
            endcase
        end
    end

`ifdef UART_STRESS_TIMEOUT_EN
    localparam int unsigned wd_w = $clog2(timeout_cycles_p + 1);
    logic [wd_w-1:0] wd_cnt;

    // Outside check states the counter is held at zero, so entering a check mode restarts it.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (clear_i)
                timeout_o <= 1'b0;
            if (!chk_active || rx_v_i || clear_i) begin
                wd_cnt <= '0;
            end else if (wd_cnt != wd_w'(timeout_cycles_p)) begin
                wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt == wd_w'(timeout_cycles_p - 1))
                    timeout_o <= 1'b1;
            end
        end
    end
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_stress_engine.sv
module tb_uart_stress_engine;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       clear = 1'b0;
    logic       rx_v = 1'b0;
    logic [7:0] rx_d = 8'h00;
    logic       rx_pe = 1'b0;
    logic       rx_fe = 1'b0;
    logic       tx_v;
    logic [7:0] tx_d;
    logic       tx_rdy = 1'b0;
    logic [7:0] rx_cnt, tx_cnt, par_cnt, frm_cnt, ovf_cnt, mis_cnt;
    logic [3:0] sticky;
    logic       timeout;

    int total = 0;
    int bad   = 0;
    logic [7:0] txq[$];

    uart_stress_engine #(
        .data_bits_p(8), .buffer_els_p(16), .count_width_p(8),
        .lfsr_seed_p(16'hACE1), .timeout_cycles_p(100)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .mode_i(mode), .clear_i(clear),
        .rx_v_i(rx_v), .rx_i(rx_d), .rx_parity_error_i(rx_pe), .rx_frame_error_i(rx_fe),
        .tx_v_o(tx_v), .tx_o(tx_d), .tx_ready_and_i(tx_rdy),
        .rx_count_o(rx_cnt), .tx_count_o(tx_cnt), .parity_err_count_o(par_cnt),
        .frame_err_count_o(frm_cnt), .overflow_count_o(ovf_cnt), .mismatch_count_o(mis_cnt),
        .sticky_o(sticky), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so the negedge view is the handshake the next edge will take.
    always @(negedge clk)
        if (reset_n && tx_v && tx_rdy)
            txq.push_back(tx_d);

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic pe, input logic fe);
        rx_v = 1'b1; rx_d = b; rx_pe = pe; rx_fe = fe;
        tick(1);
        rx_v = 1'b0; rx_pe = 1'b0; rx_fe = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic test_reset();
        tick(4);
        total++; if (tx_v !== 1'b0) begin bad++; $display("FAIL reset_tx_v got=%0h want=0", tx_v); end
        total++; if (rx_cnt !== 8'd0) begin bad++; $display("FAIL reset_rx_count got=%0h want=0", rx_cnt); end
        total++; if (sticky !== 4'b0000) begin bad++; $display("FAIL reset_sticky got=%0b want=0000", sticky); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%0h want=0", timeout); end
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_echo();
        txq.delete();
        tx_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(8'(i), 1'b0, 1'b0);
            tick(9);
        end
        tx_rdy = 1'b0;
        total++; if (txq.size() != 16) begin bad++; $display("FAIL echo_len got=%0d want=16", txq.size()); end
        for (int i = 0; i < 16 && i < txq.size(); i++) begin
            total++; if (txq[i] !== 8'(i)) begin bad++; $display("FAIL echo_byte%0d got=%0h want=%0h", i, txq[i], i); end
        end
        total++; if (tx_cnt !== 8'd16) begin bad++; $display("FAIL echo_tx_count got=%0d want=16", tx_cnt); end
        total++; if (rx_cnt !== 8'd16) begin bad++; $display("FAIL echo_rx_count got=%0d want=16", rx_cnt); end
        total++; if ({par_cnt, frm_cnt, ovf_cnt, mis_cnt} !== 32'd0) begin bad++; $display("FAIL echo_err_counts got=%0h want=0", {par_cnt, frm_cnt, ovf_cnt, mis_cnt}); end
    endtask

    task automatic test_overflow();
        do_clear();
        for (int i = 0; i < 20; i++)
            send(8'h20 + 8'(i), 1'b0, 1'b0);
        total++; if (ovf_cnt !== 8'd4) begin bad++; $display("FAIL ovf_count got=%0d want=4", ovf_cnt); end
        total++; if (sticky !== 4'b0100) begin bad++; $display("FAIL ovf_sticky got=%0b want=0100", sticky); end
        total++; if (tx_cnt !== 8'd0) begin bad++; $display("FAIL ovf_tx_count got=%0d want=0", tx_cnt); end
        txq.delete();
        tx_rdy = 1'b1;
        tick(30);
        tx_rdy = 1'b0;
        total++; if (txq.size() != 16) begin bad++; $display("FAIL ovf_drain_len got=%0d want=16", txq.size()); end
        for (int i = 0; i < 16 && i < txq.size(); i++) begin
            total++; if (txq[i] !== 8'h20 + 8'(i)) begin bad++; $display("FAIL ovf_byte%0d got=%0h want=%0h", i, txq[i], 8'h20 + 8'(i)); end
        end
        total++; if (tx_v !== 1'b0) begin bad++; $display("FAIL ovf_empty_tx_v got=%0h want=0", tx_v); end
    endtask

    task automatic test_gen();
        logic [15:0] s;
        mode = 2'd1;
        tick(3);
        do_clear();
        txq.delete();
        tx_rdy = 1'b1;
        tick(10);
        tx_rdy = 1'b0;
        total++; if (txq.size() != 10) begin bad++; $display("FAIL gen_len got=%0d want=10", txq.size()); end
        total++; if (txq.size() > 3 && txq[0:3] != '{8'hE1, 8'h70, 8'h38, 8'h9C}) begin bad++; $display("FAIL gen_first4 got=%0h %0h %0h %0h want=e1 70 38 9c", txq[0], txq[1], txq[2], txq[3]); end
        s = 16'hACE1;
        for (int i = 0; i < 10 && i < txq.size(); i++) begin
            total++; if (txq[i] !== s[7:0]) begin bad++; $display("FAIL gen_byte%0d got=%0h want=%0h", i, txq[i], s[7:0]); end
            s = lstep(s);
        end
        total++; if (tx_cnt !== 8'd10) begin bad++; $display("FAIL gen_tx_count got=%0d want=10", tx_cnt); end
    endtask

    task automatic test_genchk_loopback();
        logic [7:0] b;
        mode = 2'd3;
        tick(3);
        // The offered generator byte must stay valid across the mode change until taken.
        total++; if (tx_v !== 1'b1) begin bad++; $display("FAIL pend_hold got=%0h want=1", tx_v); end
        tx_rdy = 1'b1;
        tick(1);
        tx_rdy = 1'b0;
        tick(2);
        total++; if (tx_d !== 8'hE1) begin bad++; $display("FAIL genchk_reseed got=%0h want=e1", tx_d); end
        do_clear();
        for (int i = 0; i < 1000; i++) begin
            b = tx_d;
            tx_rdy = 1'b1;
            tick(1);
            tx_rdy = 1'b0;
            send(b, 1'b0, 1'b0);
        end
        txq.delete();
        total++; if (mis_cnt !== 8'd0) begin bad++; $display("FAIL loop_mismatch got=%0d want=0", mis_cnt); end
        total++; if (tx_cnt !== 8'hFF) begin bad++; $display("FAIL loop_tx_sat got=%0h want=ff", tx_cnt); end
        total++; if (rx_cnt !== 8'hFF) begin bad++; $display("FAIL loop_rx_sat got=%0h want=ff", rx_cnt); end
    endtask

    task automatic test_check();
        logic [15:0] s;
        logic [7:0]  b;
        mode = 2'd2;
        tick(1);
        tx_rdy = 1'b1;
        tick(1);
        tx_rdy = 1'b0;
        tick(2);
        total++; if (tx_v !== 1'b0) begin bad++; $display("FAIL check_tx_v got=%0h want=0", tx_v); end
        do_clear();
        s = 16'hACE1;
        for (int i = 0; i < 12; i++) begin
            b = s[7:0];
            if (i == 5)
                b = b ^ 8'hFF;
            send(b, 1'b0, i == 9);
            tick(1);
            s = lstep(s);
        end
        total++; if (mis_cnt !== 8'd1) begin bad++; $display("FAIL check_mismatch got=%0d want=1", mis_cnt); end
        total++; if (frm_cnt !== 8'd1) begin bad++; $display("FAIL check_frame got=%0d want=1", frm_cnt); end
        total++; if (par_cnt !== 8'd0) begin bad++; $display("FAIL check_parity got=%0d want=0", par_cnt); end
        total++; if (sticky !== 4'b1010) begin bad++; $display("FAIL check_sticky got=%0b want=1010", sticky); end
        total++; if (rx_cnt !== 8'd12) begin bad++; $display("FAIL check_rx_count got=%0d want=12", rx_cnt); end
    endtask

    task automatic test_drain_and_reset();
        logic [7:0] exp [7] = '{8'hA1, 8'hA2, 8'hA3, 8'hE1, 8'h70, 8'h38, 8'h9C};
        mode = 2'd0;
        tick(3);
        send(8'hA1, 1'b0, 1'b0);
        send(8'hA2, 1'b0, 1'b0);
        send(8'hA3, 1'b0, 1'b0);
        mode = 2'd1;
        tick(2);
        total++; if (tx_v !== 1'b1 || tx_d !== 8'hA1) begin bad++; $display("FAIL drain_head got=%0h/%0h want=1/a1", tx_v, tx_d); end
        txq.delete();
        tx_rdy = 1'b1;
        tick(8);
        tx_rdy = 1'b0;
        total++; if (txq.size() != 7) begin bad++; $display("FAIL drain_len got=%0d want=7", txq.size()); end
        for (int i = 0; i < 7 && i < txq.size(); i++) begin
            total++; if (txq[i] !== exp[i]) begin bad++; $display("FAIL drain_byte%0d got=%0h want=%0h", i, txq[i], exp[i]); end
        end
        total++; if (tx_cnt !== 8'd7) begin bad++; $display("FAIL drain_tx_count got=%0d want=7", tx_cnt); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (tx_v !== 1'b0) begin bad++; $display("FAIL async_reset_tx_v got=%0h want=0", tx_v); end
        total++; if (tx_cnt !== 8'd0 || sticky !== 4'b0000) begin bad++; $display("FAIL async_reset_counts got=%0h/%0b want=0/0000", tx_cnt, sticky); end
        mode = 2'd0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_saturation_clear();
        rx_v = 1'b1; rx_pe = 1'b1;
        tick(261);
        rx_v = 1'b0; rx_pe = 1'b0;
        total++; if (par_cnt !== 8'hFF) begin bad++; $display("FAIL sat_parity got=%0h want=ff", par_cnt); end
        total++; if (sticky !== 4'b0001) begin bad++; $display("FAIL sat_sticky got=%0b want=0001", sticky); end
        total++; if (ovf_cnt !== 8'd0) begin bad++; $display("FAIL sat_overflow got=%0d want=0", ovf_cnt); end
        rx_v = 1'b1; rx_fe = 1'b1; clear = 1'b1;
        tick(1);
        rx_v = 1'b0; rx_fe = 1'b0; clear = 1'b0;
        total++; if (frm_cnt !== 8'd0 || par_cnt !== 8'd0) begin bad++; $display("FAIL clear_wins got=%0h/%0h want=0/0", frm_cnt, par_cnt); end
        total++; if (sticky !== 4'b0000) begin bad++; $display("FAIL clear_sticky got=%0b want=0000", sticky); end
    endtask

    task automatic test_timeout();
        mode = 2'd2;
        tick(2);
`ifdef UART_STRESS_TIMEOUT_EN
        tick(99);
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_early got=%0h want=0", timeout); end
        tick(1);
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL timeout_at_100 got=%0h want=1", timeout); end
        do_clear();
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%0h want=0", timeout); end
`else
        tick(150);
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_tied got=%0h want=0", timeout); end
`endif
    endtask

    initial begin
        test_reset();
        test_echo();
        test_overflow();
        test_gen();
        test_genchk_loopback();
        test_check();
        test_drain_and_reset();
        test_saturation_clear();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
